// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x3 telephone-style key matrix, debounces whole-matrix frames and
//   presents the accepted key as one-hot digit levels plus separate * / #
//   levels, with a single-cycle strobe for each newly accepted press.
//
// Ports
//   clock      : system clock, all state on the rising edge
//   reset      : asynchronous, active-high reset
//   col_n[2:0] : matrix columns, active-low, asynchronous to clock
//   row_n[3:0] : matrix rows, active-low, exactly one low at any time
//   keypad[9:0]: debounced one-hot digit keys, bit n = digit n held
//   key_star   : debounced * held
//   key_hash   : debounced # held
//   key_strobe : one-cycle pulse when a press is accepted
//
// Parameters
//   SCAN_DIV   : clock cycles each row is held active (>= 4)
//   DEBOUNCE   : consecutive identical frames to accept a press/release (>= 1)

module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_strobe
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Column synchronizer
    // ------------------------------------------------------------------
    logic [2:0] col_meta;
    logic [2:0] col_sync;

    // Cleared to the idle (pulled-up) level so reset never looks like keys.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    // ------------------------------------------------------------------
    // Row scan and per-row sampling
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [11:0]      frame;        // bit row*3+col set = key down
    logic             frame_valid;  // high on the frame-result cycle
    logic             row_end;

    assign row_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            row_idx     <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= row_end && (row_idx == 2'd3);
            if (row_end) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                case (row_idx)
                    2'd0:    frame[2:0]   <= ~col_sync;
                    2'd1:    frame[5:3]   <= ~col_sync;
                    2'd2:    frame[8:6]   <= ~col_sync;
                    default: frame[11:9]  <= ~col_sync;
                endcase
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        row_n          = '1;
        row_n[row_idx] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Frame classification: NONE / SINGLE(hit_code) / MULTI
    // ------------------------------------------------------------------
    logic [3:0] hits;
    logic [3:0] hit_code;
    logic       single;

    always_comb begin
        hits     = '0;
        hit_code = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (frame[i]) begin
                hits     = hits + 4'd1;
                hit_code = 4'(i);
            end
        end
        single = (hits == 4'd1);
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           state, state_n;
    logic [3:0]       cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             match;
    logic [9:0]       keypad_n;
    logic             star_n;
    logic             hash_n;
    logic             strobe_n;

    assign cnt_inc = cnt + CNT_ONE;
    assign match   = single && (hit_code == cand);

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        if (frame_valid) begin
            case (state)
                ST_IDLE: begin
                    if (single) begin
                        cand_n  = hit_code;
                        cnt_n   = CNT_ONE;
                        state_n = (DEBOUNCE == 1) ? ST_PRESSED : ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (match) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            state_n = ST_PRESSED;
                        end
                    end else if (single) begin
                        cand_n = hit_code;
                        cnt_n  = CNT_ONE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    // A different key counts as a release frame (no rollover).
                    if (!match) begin
                        cnt_n   = CNT_ONE;
                        state_n = (DEBOUNCE == 1) ? ST_IDLE : ST_RELEASE;
                    end
                end
                default: begin // ST_RELEASE
                    if (match) begin
                        state_n = ST_PRESSED;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB_LAST) begin
                            state_n = ST_IDLE;
                        end
                    end
                end
            endcase
        end

        // Outputs are derived from the next state so they change on the
        // same edge the FSM enters or leaves the held states.
        keypad_n = '0;
        star_n   = 1'b0;
        hash_n   = 1'b0;
        if (state_n == ST_PRESSED || state_n == ST_RELEASE) begin
            case (cand_n)
                4'd0:    keypad_n[1] = 1'b1;
                4'd1:    keypad_n[2] = 1'b1;
                4'd2:    keypad_n[3] = 1'b1;
                4'd3:    keypad_n[4] = 1'b1;
                4'd4:    keypad_n[5] = 1'b1;
                4'd5:    keypad_n[6] = 1'b1;
                4'd6:    keypad_n[7] = 1'b1;
                4'd7:    keypad_n[8] = 1'b1;
                4'd8:    keypad_n[9] = 1'b1;
                4'd9:    star_n      = 1'b1;
                4'd10:   keypad_n[0] = 1'b1;
                default: hash_n      = 1'b1;
            endcase
        end
        strobe_n = (state_n == ST_PRESSED) &&
                   (state == ST_IDLE || state == ST_CONFIRM);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cand       <= '0;
            cnt        <= '0;
            keypad     <= '0;
            key_star   <= 1'b0;
            key_hash   <= 1'b0;
            key_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            cand       <= cand_n;
            cnt        <= cnt_n;
            keypad     <= keypad_n;
            key_star   <= star_n;
            key_hash   <= hash_n;
            key_strobe <= strobe_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3.
//   A matrix model turns the set of held keys into col_n from row_n. Keys
//   change only at frame boundaries; each cycle row_n, the key levels and
//   the strobe are compared with expectations from a directed table or from
//   a frame-level reference model.

module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       key_star;
    logic       key_hash;
    logic       key_strobe;

    logic [11:0] keys = '0;   // bit row*3+col = key physically held

    int checks   = 0;
    int failures = 0;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .col_n     (col_n),
        .row_n     (row_n),
        .keypad    (keypad),
        .key_star  (key_star),
        .key_hash  (key_hash),
        .key_strobe(key_strobe)
    );

    always #5 clock = ~clock;

    // Passive matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!row_n[r] && keys[r*3+c]) col_n[c] = 1'b0;
    end

    // Expected outputs packed as {keypad[9:0], key_star, key_hash}.
    logic [11:0] exp_outs   = '0;
    logic        exp_strobe = 1'b0;

    typedef struct {
        logic [11:0] keys;
        logic [11:0] outs;
        logic        strobe;
    } vec_t;
    vec_t tbl[$];

    localparam logic [11:0] STAR_M = 12'h200;
    localparam logic [11:0] HASH_M = 12'h800;
    localparam logic [11:0] O_STAR = 12'h002;
    localparam logic [11:0] O_HASH = 12'h001;
    localparam logic [11:0] NONE   = 12'h000;

    // Matrix mask for a digit key.
    function automatic logic [11:0] kd(input int d);
        logic [11:0] v;
        v = '0;
        v[(d == 0) ? 10 : d - 1] = 1'b1;
        return v;
    endfunction

    // Expected packed outputs for a held digit.
    function automatic logic [11:0] od(input int d);
        logic [11:0] v;
        v = '0;
        v[d + 2] = 1'b1;
        return v;
    endfunction

    function automatic logic [11:0] outs_for(input int code);
        if (code < 0)   return '0;
        if (code == 9)  return O_STAR;
        if (code == 11) return O_HASH;
        if (code == 10) return od(0);
        return od(code + 1);
    endfunction

    task automatic add(input logic [11:0] k, input logic [11:0] o, input logic s);
        vec_t v;
        v.keys   = k;
        v.outs   = o;
        v.strobe = s;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: held = accepted key code or -1; streak counts matching
    // frames while unaccepted; rel counts non-matching frames while accepted.
    int m_held   = -1;
    int m_cand   = 0;
    int m_streak = 0;
    int m_rel    = 0;

    task automatic model_reset();
        m_held   = -1;
        m_cand   = 0;
        m_streak = 0;
        m_rel    = 0;
    endtask

    task automatic model_step(input logic [11:0] k, output logic [11:0] o, output logic s);
        int n;
        int code;
        n    = 0;
        code = -1;
        for (int i = 0; i < 12; i++)
            if (k[i]) begin
                n++;
                code = i;
            end
        if (n != 1) code = -1;
        s = 1'b0;
        if (m_held < 0) begin
            if (code >= 0) begin
                if (m_streak > 0 && code == m_cand) m_streak++;
                else begin
                    m_cand   = code;
                    m_streak = 1;
                end
                if (m_streak >= DEBOUNCE) begin
                    m_held = m_cand;
                    m_rel  = 0;
                    s      = 1'b1;
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            if (code == m_held) m_rel = 0;
            else begin
                m_rel++;
                if (m_rel >= DEBOUNCE) begin
                    m_held   = -1;
                    m_streak = 0;
                end
            end
        end
        o = outs_for(m_held);
    endtask

    // Hold k for one frame; every cycle compare against the outputs
    // expected from the frames already completed.
    task automatic run_frame(input logic [11:0] k);
        logic [3:0] er;
        logic       es;
        keys = k;
        for (int p = 1; p <= FRAME; p++) begin
            @(posedge clock);
            #1;
            er = '1;
            er[(p % FRAME) / SCAN_DIV] = 1'b0;
            es = (p == 1) ? exp_strobe : 1'b0;
            check("row_n", {8'b0, row_n}, {8'b0, er});
            check("key_levels", {keypad, key_star, key_hash}, exp_outs);
            check("key_strobe", {11'b0, key_strobe}, {11'b0, es});
        end
    endtask

    task automatic do_reset(input logic [11:0] k);
        @(negedge clock);
        reset = 1'b1;
        keys  = k;
        #1;
        check("reset_row_n", {8'b0, row_n}, 12'h00E);
        check("reset_levels", {keypad, key_star, key_hash}, 12'h000);
        check("reset_strobe", {11'b0, key_strobe}, 12'h000);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset      = 1'b0;
        exp_outs   = '0;
        exp_strobe = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [11:0] k;
        logic [11:0] prev;
        int          fav;
        int          other;

        // Idle scan
        add(NONE, NONE, 0); add(NONE, NONE, 0);
        // Clean "7" held 10 frames then released
        add(kd(7), NONE, 0); add(kd(7), NONE, 0); add(kd(7), od(7), 1);
        repeat (7) add(kd(7), od(7), 0);
        add(NONE, od(7), 0); add(NONE, od(7), 0); add(NONE, NONE, 0);
        // "5" bouncing every frame, then held
        add(kd(5), NONE, 0); add(NONE, NONE, 0); add(kd(5), NONE, 0); add(NONE, NONE, 0);
        add(kd(5), NONE, 0); add(kd(5), NONE, 0); add(kd(5), od(5), 1); add(kd(5), od(5), 0);
        add(NONE, od(5), 0); add(NONE, od(5), 0); add(NONE, NONE, 0);
        // "1"+"2" together, then "2" released
        repeat (5) add(kd(1) | kd(2), NONE, 0);
        add(kd(1), NONE, 0); add(kd(1), NONE, 0); add(kd(1), od(1), 1); add(kd(1), od(1), 0);
        add(NONE, od(1), 0); add(NONE, od(1), 0); add(NONE, NONE, 0);
        // "#" then "*"
        add(HASH_M, NONE, 0); add(HASH_M, NONE, 0); add(HASH_M, O_HASH, 1); add(HASH_M, O_HASH, 0);
        add(NONE, O_HASH, 0); add(NONE, O_HASH, 0); add(NONE, NONE, 0);
        add(STAR_M, NONE, 0); add(STAR_M, NONE, 0); add(STAR_M, O_STAR, 1); add(STAR_M, O_STAR, 0);
        add(NONE, O_STAR, 0); add(NONE, O_STAR, 0); add(NONE, NONE, 0);
        // One-frame drop while pressed returns to pressed without a strobe
        add(kd(3), NONE, 0); add(kd(3), NONE, 0); add(kd(3), od(3), 1);
        add(NONE, od(3), 0); add(kd(3), od(3), 0);
        add(NONE, od(3), 0); add(NONE, od(3), 0); add(NONE, NONE, 0);
        // No rollover: "9" then "8" needs full release and fresh confirmation
        add(kd(9), NONE, 0); add(kd(9), NONE, 0); add(kd(9), od(9), 1);
        add(kd(8), od(9), 0); add(kd(8), od(9), 0);
        add(kd(8), NONE, 0); add(kd(8), NONE, 0); add(kd(8), NONE, 0); add(kd(8), od(8), 1);
        add(NONE, od(8), 0); add(NONE, od(8), 0); add(NONE, NONE, 0);
        // Candidate switch during confirmation
        add(kd(4), NONE, 0); add(kd(4), NONE, 0);
        add(kd(6), NONE, 0); add(kd(6), NONE, 0); add(kd(6), od(6), 1);
        add(NONE, od(6), 0); add(NONE, od(6), 0); add(NONE, NONE, 0);
        // Multi-key while pressed counts toward release
        add(kd(2), NONE, 0); add(kd(2), NONE, 0); add(kd(2), od(2), 1);
        add(kd(2) | kd(3), od(2), 0); add(kd(2) | kd(3), od(2), 0); add(kd(2) | kd(3), NONE, 0);
        add(NONE, NONE, 0);

        do_reset(NONE);
        for (int i = 0; i < tbl.size(); i++) begin
            run_frame(tbl[i].keys);
            exp_outs   = tbl[i].outs;
            exp_strobe = tbl[i].strobe;
        end
        run_frame(NONE);

        // Reset mid-press with "0" held, then re-acceptance
        do_reset(kd(0));
        run_frame(kd(0)); run_frame(kd(0)); run_frame(kd(0));
        exp_outs = od(0); exp_strobe = 1'b1;
        run_frame(kd(0));
        exp_strobe = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("pre_reset_levels", {keypad, key_star, key_hash}, od(0));
        do_reset(kd(0));
        run_frame(kd(0)); run_frame(kd(0)); run_frame(kd(0));
        exp_outs = od(0); exp_strobe = 1'b1;
        run_frame(kd(0));
        exp_strobe = 1'b0;
        run_frame(NONE); run_frame(NONE); run_frame(NONE);
        exp_outs = NONE;
        run_frame(NONE);

        // Randomized frames against the reference model
        do_reset(NONE);
        prev = '0;
        fav  = int'($urandom_range(0, 11));
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 9) < 5) begin
                k = prev;
            end else begin
                if ($urandom_range(0, 3) == 0) fav = int'($urandom_range(0, 11));
                k = '0;
                case ($urandom_range(0, 7))
                    0, 1: k = '0;
                    2, 3, 4, 5: k[fav] = 1'b1;
                    6: begin
                        other    = int'($urandom_range(0, 11));
                        k[other] = 1'b1;
                    end
                    default: begin
                        other    = (fav + 1 + int'($urandom_range(0, 10))) % 12;
                        k[fav]   = 1'b1;
                        k[other] = 1'b1;
                    end
                endcase
            end
            prev = k;
            run_frame(k);
            model_step(k, exp_outs, exp_strobe);
        end
        run_frame(NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x3 telephone-style key matrix and debounces it.
- Delivers the debounced key state on the 10-bit one-hot keypad bus that the microwave encoder consumes: keypad[n] means digit n is held.
- Also flags * and # as separate levels and raises a single-cycle strobe on each newly accepted press.
- Sits between the physical matrix pins and the encoder; it is the driving end of the keypad interface.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is held active. Must be >= 4.
- DEBOUNCE, 4: consecutive identical full-matrix frames needed to accept a press or a release. Must be >= 1.

Ports:
- clock, input, 1: system clock; all state is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- col_n, input, 3: matrix columns, active-low (pulled up), asynchronous to clock.
- row_n, output, 4: matrix rows, active-low; exactly one bit is low at any time.
- keypad, output, 10: debounced one-hot digit keys; bit n = digit n held.
- key_star, output, 1: debounced * held.
- key_hash, output, 1: debounced # held.
- key_strobe, output, 1: one-cycle pulse when a press is accepted.

Behaviour:
- Reset values: row_n=4'b1110, keypad=0, key_star=0, key_hash=0, key_strobe=0. Dwell counter, row index, synchronizer, candidate, debounce counter and FSM all clear; FSM enters IDLE. Asserting reset mid-scan or mid-press returns immediately to these values.
- Key map (row,col):
  - row0: 1,2,3
  - row1: 4,5,6
  - row2: 7,8,9
  - row3: *,0,#
  - col index 0 is the leftmost key in each row.
- Synchronizer: col_n passes through a 2-flop synchronizer before any use.
- Scan: the dwell counter runs 0..SCAN_DIV-1 for each row.
  - At count SCAN_DIV-1, the synchronized columns are sampled into a per-row slot.
  - On the next cycle the row index advances (0→1→2→3→0) and row_n rotates.
  - One frame = 4*SCAN_DIV cycles.
- Frame result: evaluated the cycle after the row3 sample. It is one of:
  - NONE: no column low in any row.
  - SINGLE(k): exactly one key down across all 12 positions.
  - MULTI: two or more keys down. MULTI is treated exactly as NONE.
- Debounce FSM: updates once per frame, on the frame-result cycle. cnt is the debounce counter.
  - IDLE:
    - SINGLE(k) → cand=k, cnt=1. Go to PRESSED if DEBOUNCE==1, else CONFIRM.
    - Otherwise stay in IDLE.
  - CONFIRM:
    - SINGLE(cand) → cnt+1; on reaching DEBOUNCE → PRESSED.
    - SINGLE(other) → cand=other, cnt=1.
    - NONE/MULTI → IDLE.
  - PRESSED:
    - SINGLE(cand) → stay.
    - Anything else → cnt=1; go to IDLE if DEBOUNCE==1, else RELEASE.
  - RELEASE:
    - SINGLE(cand) → PRESSED (outputs unchanged).
    - Anything else → cnt+1; on reaching DEBOUNCE → IDLE.
- No rollover: a different key while in PRESSED counts as a release frame. The new key is accepted only after a full release and then a fresh confirmation.
- Outputs are registered and change on the same edge the FSM enters PRESSED, or enters IDLE from PRESSED/RELEASE.
  - While in PRESSED or RELEASE, exactly one of {keypad bit, key_star, key_hash} is high, selected by cand.
  - In IDLE and CONFIRM, all key outputs are 0.
- key_strobe is high only on the cycle of entry into PRESSED from CONFIRM or IDLE. It is not raised on RELEASE→PRESSED.
- Latency: from a clean press stable before the row's sample point, outputs assert DEBOUNCE frames later, plus 1 cycle, plus sync delay.
- A glitch shorter than one frame never reaches the outputs when DEBOUNCE >= 2.

Test Plan:
- Use SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles) for all scenarios.
- Reset/scan: release reset, no keys → row_n sequence 1110,1101,1011,0111 each for 4 cycles, repeating; keypad=0 and key_strobe=0 throughout.
- Clean press "7" (row2,col0) held 10 frames, then released → keypad=10'b0010000000 after the 3rd matching frame; key_strobe exactly one pulse; keypad returns to 0 after 3 NONE frames.
- Bounce: "5" toggled on/off every frame for 4 frames, then held → no output until 3 consecutive matching frames; a single strobe; keypad[5]=1.
- Multi-key: "1" and "2" held together for 5 frames → all outputs stay 0. Then release "2" → keypad[1]=1 after 3 frames.
- Special keys: hold "#" → key_hash=1, keypad=0, one strobe. Hold "*" → key_star=1.
- Reset mid-press: assert reset while keypad[0]=1 → all outputs 0 and row_n=1110 immediately. After release of reset with "0" still held, keypad[0] reasserts 3 frames later with a new strobe.
